// File: rtl/dma_stream_accumulator_pkg.sv
// Shared definitions for the DMA stream accumulator: register map, FSM encoding, STATUS layout.
package dma_stream_accumulator_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_LENGTH  = 2'd1;
    localparam logic [1:0] ADDR_CONTROL = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    // One-hot so the encoding lines up with the sequencer that drives this block.
    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_ARMED = 4'b0010,
        S_DRAIN = 4'b0100,
        S_DONE  = 4'b1000
    } state_t;

    localparam int ST_BUSY     = 0;
    localparam int ST_DONE     = 1;
    localparam int ST_OVERFLOW = 2;
    localparam int ST_DROPPED  = 3;

endpackage

// File: rtl/dma_stream_accumulator_fifo.sv
// Generic synchronous FIFO; combinational read of the head entry, one-cycle write.
// Full/empty are registered, so a write port stalled on full never sees a path from pop.
module sync_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + CNT_ONE;
            2'b01:   count_nxt = count - CNT_ONE;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            count <= count_nxt;
            full  <= (count_nxt == CNT_FULL);
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/dma_stream_accumulator.sv
// Avalon-MM write target that sums a programmed-length DMA stream and pulses the result out.
// Last word into an empty FIFO -> out_valid after 4 clocks; DATA writes stall only when ARMED and the FIFO is full.
module dma_stream_accumulator
    import dma_stream_accumulator_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 40,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [1:0]              slave_address,
    input  logic                    slave_chipselect,
    input  logic                    slave_write,
    input  logic [DATA_WIDTH-1:0]   slave_writedata,
    input  logic [DATA_WIDTH/8-1:0] slave_byteenable,
    input  logic                    slave_read,
    output logic [31:0]             slave_readdata,
    output logic                    slave_waitrequest,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_valid
);
    localparam int BE_W = DATA_WIDTH / 8;
    localparam int FW   = DATA_WIDTH + BE_W;
    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    state_t                state;
    state_t                state_nxt;
    logic                  data_req;
    logic                  len_wr;
    logic                  len_arm;
    logic                  abort;
    logic                  push;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_flush;
    logic [FW-1:0]         fifo_dat;
    logic [DATA_WIDTH-1:0] masked;
    logic [DATA_WIDTH-1:0] s1_dat;
    logic                  s1_vld;
    logic [ACC_WIDTH-1:0]  acc;
    logic [ACC_WIDTH-1:0]  acc_sum;
    logic [LEN_WIDTH:0]    len_round;
    logic [LEN_WIDTH-1:0]  words;
    logic [LEN_WIDTH-1:0]  remaining;
    logic                  done;
    logic                  overflow;
    logic                  dropped;
    logic                  drop_evt;
    logic [31:0]           status;

    assign data_req = slave_chipselect & slave_write & (slave_address == ADDR_DATA);
    assign len_wr   = slave_chipselect & slave_write & (slave_address == ADDR_LENGTH);
    assign abort    = slave_chipselect & slave_write & (slave_address == ADDR_CONTROL) & slave_writedata[0];
    assign len_arm  = len_wr & (state == S_IDLE);

    assign slave_waitrequest = data_req & (state == S_ARMED) & fifo_full;
    assign push = data_req & (state == S_ARMED) & ~fifo_full;
    // The write port has priority: a pop yields to a same-cycle push, so bursts fill the FIFO.
    assign pop  = (state == S_ARMED) & ~fifo_empty & (remaining != '0) & ~push;
    assign fifo_flush = abort | (state == S_DONE);

    assign len_round = {1'b0, slave_writedata[LEN_WIDTH-1:0]} + (LEN_WIDTH + 1)'(3);
    assign words     = LEN_WIDTH'(len_round[LEN_WIDTH:2]);
    assign acc_sum   = acc + ACC_WIDTH'(s1_dat);

    assign drop_evt = (data_req & (state != S_ARMED))
                    | (len_wr & (state != S_IDLE))
                    | ((state == S_DONE) & ~fifo_empty);

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (fifo_flush),
        .push      (push),
        .push_data ({slave_byteenable, slave_writedata}),
        .pop       (pop),
        .pop_data  (fifo_dat),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        masked = '0;
        for (int i = 0; i < BE_W; i++) begin
            if (fifo_dat[DATA_WIDTH + i]) masked[8*i +: 8] = fifo_dat[8*i +: 8];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (len_wr) state_nxt = (words == '0) ? S_DONE : S_ARMED;
            S_ARMED: if (pop && remaining == LEN_ONE) state_nxt = S_DRAIN;
            S_DRAIN: if (!s1_vld) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            remaining <= '0;
            s1_vld    <= 1'b0;
            s1_dat    <= '0;
            acc       <= '0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            dropped   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= (state == S_DONE) & ~abort;
            s1_vld    <= pop & ~abort;
            if (pop) s1_dat <= masked;

            if (abort)        remaining <= '0;
            else if (len_arm) remaining <= words;
            else if (pop)     remaining <= remaining - LEN_ONE;

            if (len_arm) begin
                acc      <= '0;
                overflow <= 1'b0;
            end else if (s1_vld && !abort) begin
                acc <= acc_sum;
                if (|acc_sum[ACC_WIDTH-1:DATA_WIDTH]) overflow <= 1'b1;
            end

            if (len_arm)                           done <= 1'b0;
            else if (state == S_DONE && !abort)    done <= 1'b1;
            if (state == S_DONE && !abort)         out_data <= acc[DATA_WIDTH-1:0];
            if (drop_evt)                          dropped <= 1'b1;
        end
    end

    always_comb begin
        status = '0;
        status[ST_BUSY]     = (state != S_IDLE);
        status[ST_DONE]     = done;
        status[ST_OVERFLOW] = overflow;
        status[ST_DROPPED]  = dropped;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slave_readdata <= '0;
        end else if (slave_chipselect && slave_read) begin
            case (slave_address)
                ADDR_DATA:    slave_readdata <= 32'(acc[DATA_WIDTH-1:0]);
                ADDR_LENGTH:  slave_readdata <= 32'(remaining);
                ADDR_CONTROL: slave_readdata <= '0;
                ADDR_STATUS:  slave_readdata <= status;
                default:      slave_readdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_stream_accumulator.sv
// Scoreboard bench for dma_stream_accumulator: expected sums queued at stimulus, popped on out_valid.
module tb_dma_stream_accumulator;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  slave_address;
    logic        slave_chipselect;
    logic        slave_write;
    logic [31:0] slave_writedata;
    logic [3:0]  slave_byteenable;
    logic        slave_read;
    logic [31:0] slave_readdata;
    logic        slave_waitrequest;
    logic [31:0] out_data;
    logic        out_valid;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_acc = 0;
    int ov_cyc = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dma_stream_accumulator dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .slave_address     (slave_address),
        .slave_chipselect  (slave_chipselect),
        .slave_write       (slave_write),
        .slave_writedata   (slave_writedata),
        .slave_byteenable  (slave_byteenable),
        .slave_read        (slave_read),
        .slave_readdata    (slave_readdata),
        .slave_waitrequest (slave_waitrequest),
        .out_data          (out_data),
        .out_valid         (out_valid)
    );

    function automatic logic [31:0] mask_be(input logic [31:0] d, input logic [3:0] be);
        return d & {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    task automatic bus_idle();
        slave_address = 2'd0; slave_chipselect = 1'b0; slave_write = 1'b0;
        slave_writedata = '0; slave_byteenable = '0; slave_read = 1'b0;
    endtask

    task automatic do_reset();
        bus_idle();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be, output int stalls);
        stalls = 0;
        @(negedge clk);
        slave_address = a; slave_chipselect = 1'b1; slave_write = 1'b1;
        slave_writedata = d; slave_byteenable = be;
        #1;
        while (slave_waitrequest && stalls < 100) begin
            stalls++;
            @(negedge clk); #1;
        end
        if (stalls >= 100) begin
            total++; bad++;
            $display("FAIL write_timeout addr=%0d waitrequest stuck high, required release", a);
        end
        @(posedge clk); #1;
        last_acc = cyc;
        bus_idle();
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] v);
        @(negedge clk);
        slave_address = a; slave_chipselect = 1'b1; slave_read = 1'b1;
        @(posedge clk); #1;
        v = slave_readdata;
        bus_idle();
    endtask

    task automatic wait_out(input string nm);
        int n;
        logic [31:0] e;
        n = 0;
        @(negedge clk);
        while (out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s_timeout out_valid=%b required 1", nm, out_valid);
        end else begin
            ov_cyc = cyc;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL %s_unexpected out_data=%h with no queued result", nm, out_data);
            end else begin
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    bad++;
                    $display("FAIL %s_data out_data=%h required %h", nm, out_data, e);
                end
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] v;
        do_reset();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got %b required 0", out_valid); end
        total++; if (out_data !== 32'h0) begin bad++; $display("FAIL rst_out_data got %h required 0", out_data); end
        total++; if (slave_readdata !== 32'h0) begin bad++; $display("FAIL rst_readdata got %h required 0", slave_readdata); end
        bus_read(2'd3, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL rst_status got %h required 0", v); end
        bus_read(2'd1, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL rst_remaining got %h required 0", v); end
        bus_read(2'd0, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL rst_sum got %h required 0", v); end
    endtask

    task automatic test_basic();
        logic [31:0] v;
        logic [63:0] s;
        int st;
        s = 0;
        bus_write(2'd1, 32'd16, 4'hF, st);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            bus_write(2'd0, i, 4'hF, st);
            s += mask_be(i, 4'hF);
        end
        exp_q.push_back(s[31:0]);
        wait_out("basic");
        total++; if (ov_cyc - last_acc != 4) begin bad++; $display("FAIL basic_latency got %0d required 4", ov_cyc - last_acc); end
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_pulse out_valid=%b required 0", out_valid); end
        bus_read(2'd3, v);
        total++; if (v !== 32'h2) begin bad++; $display("FAIL basic_status got %h required 2", v); end
        bus_read(2'd1, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL basic_remaining got %h required 0", v); end
        bus_read(2'd0, v);
        total++; if (v !== 32'd10) begin bad++; $display("FAIL basic_sum got %h required %h", v, 32'd10); end
    endtask

    task automatic test_bytelanes();
        logic [63:0] s;
        int st;
        bus_write(2'd1, 32'd8, 4'hF, st);
        bus_write(2'd0, 32'hFFFFFFFF, 4'h3, st);
        bus_write(2'd0, 32'h00000005, 4'hF, st);
        s = 64'(mask_be(32'hFFFFFFFF, 4'h3)) + 64'(mask_be(32'h5, 4'hF));
        exp_q.push_back(s[31:0]);
        wait_out("bytelanes");
    endtask

    task automatic test_overflow();
        logic [31:0] v;
        logic [63:0] s;
        int st;
        s = 0;
        bus_write(2'd1, 32'd12, 4'hF, st);
        for (int i = 0; i < 3; i++) begin
            bus_write(2'd0, 32'hFFFFFFFF, 4'hF, st);
            s += 64'hFFFFFFFF;
        end
        exp_q.push_back(s[31:0]);
        wait_out("overflow");
        bus_read(2'd3, v);
        total++; if (v !== 32'h6) begin bad++; $display("FAIL overflow_status got %h required 6", v); end
    endtask

    task automatic test_back_to_back();
        int st;
        int first;
        int nstall;
        first = 0; nstall = 0;
        bus_write(2'd1, 32'd40, 4'hF, st);
        for (int i = 1; i <= 10; i++) begin
            bus_write(2'd0, 32'h1, 4'hF, st);
            nstall += st;
            if (st > 0 && first == 0) first = i;
        end
        exp_q.push_back(32'd10);
        wait_out("b2b");
        total++; if (first != 5) begin bad++; $display("FAIL b2b_first_stall got write %0d required 5", first); end
        total++; if (nstall < 1) begin bad++; $display("FAIL b2b_stalls got %0d required >=1", nstall); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        int st;
        bus_write(2'd1, 32'd16, 4'hF, st);
        bus_write(2'd0, 32'h5, 4'hF, st);
        @(negedge clk); #2;
        reset_n = 1'b0;
        #1;
        total++; if (out_data !== 32'h0) begin bad++; $display("FAIL midrst_out_data got %h required 0", out_data); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got %b required 0", out_valid); end
        total++; if (slave_readdata !== 32'h0) begin bad++; $display("FAIL midrst_readdata got %h required 0", slave_readdata); end
        @(negedge clk);
        reset_n = 1'b1;
        bus_read(2'd3, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL midrst_status got %h required 0", v); end
        bus_read(2'd1, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL midrst_remaining got %h required 0", v); end
    endtask

    task automatic test_zero_len();
        logic [31:0] v;
        int st;
        bus_write(2'd1, 32'd0, 4'hF, st);
        exp_q.push_back(32'h0);
        wait_out("zero");
        total++; if (ov_cyc - last_acc != 1) begin bad++; $display("FAIL zero_latency got %0d required 1", ov_cyc - last_acc); end
        bus_write(2'd0, 32'h7, 4'hF, st);
        total++; if (st != 0) begin bad++; $display("FAIL idle_write_stall got %0d required 0", st); end
        bus_read(2'd3, v);
        total++; if (v !== 32'hA) begin bad++; $display("FAIL idle_status got %h required a", v); end
        bus_read(2'd0, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL idle_sum got %h required 0", v); end
    endtask

    task automatic test_abort();
        logic [31:0] v;
        int st;
        int pulses;
        do_reset();
        bus_write(2'd1, 32'd16, 4'hF, st);
        bus_write(2'd0, 32'h1, 4'hF, st);
        bus_write(2'd0, 32'h2, 4'hF, st);
        repeat (6) @(negedge clk);
        bus_read(2'd1, v);
        total++; if (v !== 32'h2) begin bad++; $display("FAIL abort_remaining_pre got %h required 2", v); end
        bus_write(2'd2, 32'h1, 4'hF, st);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) pulses++;
        end
        total++; if (pulses != 0) begin bad++; $display("FAIL abort_pulses got %0d required 0", pulses); end
        bus_read(2'd3, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL abort_status got %h required 0", v); end
        bus_read(2'd0, v);
        total++; if (v !== 32'd3) begin bad++; $display("FAIL abort_sum got %h required 3", v); end
        bus_read(2'd1, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL abort_remaining got %h required 0", v); end
    endtask

    initial begin
        bus_idle();
        reset_n = 1'b0;
        test_reset();
        test_basic();
        test_bytelanes();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_zero_len();
        test_abort();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover got %0d queued results required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dma_stream_accumulator.md
Name: dma_stream_accumulator

Overview:
- Avalon-MM slave that terminates the DMA write stream programmed by the custom-instruction DMA sequencer; it is the DMA's fixed-location write target.
- Buffers incoming DMA words and sums them over a programmed byte length.
- Presents the final sum to the custom-instruction side as a one-cycle out_data/out_valid pulse.
- Replaces the bare capture slave downstream of the DMA.

Parameters:
DATA_WIDTH, 32, width of DMA words and out_data
ACC_WIDTH, 40, internal accumulator width (guard bits for overflow detect)
FIFO_DEPTH, 4, input buffer entries (power of two)
LEN_WIDTH, 16, width of programmed byte length

Ports:
clk  input  1  single clock, all logic rising-edge
reset_n  input  1  asynchronous active-low reset
slave_address  input  2  word register select
slave_chipselect  input  1  slave select
slave_write  input  1  write strobe
slave_writedata  input  32  write data
slave_byteenable  input  4  byte lanes of write data
slave_read  input  1  read strobe
slave_readdata  output  32  read data, read latency 1
slave_waitrequest  output  1  stall; high when FIFO full and the access is a DATA write
out_data  output  32  final sum (low DATA_WIDTH bits of accumulator)
out_valid  output  1  one-cycle pulse when out_data valid

Behaviour:
- Reset (async assert, sync release): all outputs 0; FIFO empty; accumulator 0; remaining count 0; state IDLE; status bits 0.
- Register map, write: addr 0 DATA (DMA stream word); addr 1 LENGTH (bytes, low LEN_WIDTH bits; arms block); addr 2 CONTROL (bit0=1 aborts); addr 3 ignored.
- Register map, read: addr 0 SUM (accumulator low 32); addr 3 STATUS {28'b0, dropped, overflow, done, busy}; addr 1 returns remaining word count; addr 2 returns 0. Readdata is valid the cycle after slave_read&chipselect; otherwise it holds its last value.
- Byte lanes: disabled lanes are zeroed before accumulation. LENGTH/CONTROL ignore byteenable.
- Word count: words = (LENGTH+3)>>2.
- States:
  - IDLE: LENGTH write -> clear acc, overflow, done; load remaining=words. If words==0 -> DONE, else ARMED. DATA write in IDLE: accepted (no stall), discarded, sets sticky dropped.
  - ARMED: DATA writes are pushed to FIFO. slave_waitrequest = chipselect & write & addr==0 & fifo_full; the write completes when waitrequest is low. Pop when FIFO non-empty and remaining>0; the popped word is masked and registered (stage 1), then added to the accumulator next cycle (stage 2). remaining decrements on pop. When remaining reaches 0 -> DRAIN.
  - DRAIN: wait until stage 1/2 are empty, then -> DONE. DATA writes beyond length: discarded, set dropped, no stall.
  - DONE: out_data <= acc[31:0], out_valid=1 for exactly one cycle, done=1 (sticky until next LENGTH write), -> IDLE.
- Latency: last accepted word -> out_valid is 4 cycles when the FIFO is empty (push, pop/mask, accumulate, DONE).
- Overflow: sticky bit set if any acc[ACC_WIDTH-1:DATA_WIDTH] is nonzero after an add (unsigned arithmetic). out_data is still the low bits.
- LENGTH write while ARMED/DRAIN: ignored, sets dropped.
- Abort (CONTROL bit0 in any state): flush FIFO and pipeline, remaining=0 -> IDLE. No out_valid; acc is retained for readback.
- Simultaneous push and pop on a full FIFO: allowed; waitrequest is computed from the registered full flag only (no combinational path from pop).
- reset_n low mid-transfer: immediate return to reset values. A partial sum is lost.
- busy = state != IDLE.

Decomposition:
- Shared package: register address constants (ADDR_DATA=0, ADDR_LENGTH=1, ADDR_CONTROL=2, ADDR_STATUS=3), state encoding (one-hot IDLE/ARMED/DRAIN/DONE, matching the one-hot style of the DMA sequencer), STATUS bit indices.
- One sub-module: sync_fifo (DATA_WIDTH+4 wide so byteenable travels with data, FIFO_DEPTH deep, full/empty flags registered).

Test Plan:
- LENGTH=16, DATA writes 1,2,3,4 all byteenable 4'hF -> out_valid pulse once with out_data=10; STATUS=4'b0010; addr1 reads 0.
- LENGTH=8, DATA 32'hFFFFFFFF (be 4'h3) then 32'h00000005 -> out_data=32'h00010004.
- LENGTH=12, DATA 32'hFFFFFFFF ×3 -> out_data=32'hFFFFFFFD, overflow=1.
- LENGTH=40, FIFO pop held off by back-to-back writes: 10 writes of 32'h1 with FIFO filling -> waitrequest asserts on the 5th write while full, no word lost, out_data=10.
- LENGTH=0 -> out_valid next-but-one cycle, out_data=0. DATA write in IDLE -> STATUS dropped=1, sum unchanged.
- LENGTH=16, two words written, CONTROL=1 -> busy=0, no out_valid, SUM reads 3 (1+2). reset_n pulsed mid-transfer -> all outputs 0.
